// File: rtl/fetch.sv
// IF stage of the RV32I pipeline: owns the PC, issues single-outstanding imem reads,
// discards responses made stale by redirects and parks one response while decode stalls.
module fetch #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] NOP      = XLEN'(32'h0000_0013)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            br_true,
    input  logic [XLEN-1:0] br_decode,
    input  logic            jal_take,
    input  logic [XLEN-1:0] jal_decode,
    input  logic            jalr_take,
    input  logic [XLEN-1:0] jalr_decode,
    input  logic            stall_if,
    output logic [XLEN-1:0] pc_decode,
    output logic [XLEN-1:0] instr_decode,
    output logic            valid_decode
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } slot_t;

    localparam slot_t BUBBLE = '{pc: '0, instr: NOP};

    state_e          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    slot_t           buf_q, buf_d;
    logic            buf_full_q, buf_full_d;
    slot_t           ifid_q, ifid_d;
    logic            ifid_valid_q, ifid_valid_d;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic            accept;
    logic            deliver;
    slot_t           rsp;

    // Redirect target priority: jalr over jal over branch
    always_comb begin
        redirect = jalr_take | jal_take | br_true;
        target   = br_decode;
        if (jalr_take) begin
            target = jalr_decode;
        end else if (jal_take) begin
            target = jal_decode;
        end
    end

    assign accept    = imem_req & imem_gnt;
    assign rsp.pc    = req_pc_q;
    assign rsp.instr = imem_rdata;
    assign imem_addr = fetch_pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a redirect while a read is outstanding turns it into a discard
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ:   if (accept) state_d = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end else if (redirect) begin
                    state_d = S_DROP;
                end
            end
            S_DROP:  if (imem_rvalid) state_d = S_REQ;
            default: state_d = S_REQ;
        endcase
    end

    // Request/deliver strobes; a full buffer or a redirect suppresses the request
    always_comb begin
        imem_req = 1'b0;
        deliver  = 1'b0;
        case (state_q)
            S_REQ:   imem_req = ~buf_full_q & ~redirect & ~rst;
            S_WAIT:  deliver  = imem_rvalid & ~redirect;
            default: ;
        endcase
    end

    // PC, skid buffer and IF/ID register update
    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        req_pc_d     = req_pc_q;
        buf_d        = buf_q;
        buf_full_d   = buf_full_q;
        ifid_d       = ifid_q;
        ifid_valid_d = ifid_valid_q;

        if (accept) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end

        if (redirect) begin
            fetch_pc_d   = target;
            buf_full_d   = 1'b0;
            ifid_d       = BUBBLE;
            ifid_valid_d = 1'b0;
        end else if (!stall_if) begin
            if (buf_full_q) begin
                ifid_d       = buf_q;
                ifid_valid_d = 1'b1;
                buf_full_d   = deliver;
                if (deliver) begin
                    buf_d = rsp;
                end
            end else if (deliver) begin
                ifid_d       = rsp;
                ifid_valid_d = 1'b1;
            end else begin
                ifid_d       = BUBBLE;
                ifid_valid_d = 1'b0;
            end
        end else if (deliver) begin
            buf_d      = rsp;
            buf_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q   <= RESET_PC;
            req_pc_q     <= '0;
            buf_q        <= BUBBLE;
            buf_full_q   <= 1'b0;
            ifid_q       <= BUBBLE;
            ifid_valid_q <= 1'b0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            req_pc_q     <= req_pc_d;
            buf_q        <= buf_d;
            buf_full_q   <= buf_full_d;
            ifid_q       <= ifid_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign pc_decode    = ifid_q.pc;
    assign instr_decode = ifid_q.instr;
    assign valid_decode = ifid_valid_q;

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed scenarios plus randomized memory/stall/redirect traffic,
// checked against an in-order instruction-stream model and a latency-programmable memory.
module tb_fetch;

    localparam int unsigned     XLEN     = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP      = 32'h0000_0013;

    logic            clk;
    logic            rst;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            br_true;
    logic [XLEN-1:0] br_decode;
    logic            jal_take;
    logic [XLEN-1:0] jal_decode;
    logic            jalr_take;
    logic [XLEN-1:0] jalr_decode;
    logic            stall_if;
    logic [XLEN-1:0] pc_decode;
    logic [XLEN-1:0] instr_decode;
    logic            valid_decode;

    int              total;
    int              bad;
    bit              chk_en;
    logic [XLEN-1:0] exp_pc;
    int              n_cons;
    bit              pend;
    logic [XLEN-1:0] pend_addr;
    int              pend_cnt;
    int              lat;
    bit              lat_rand;
    int unsigned     gnt_pct;
    bit              acc_now;
    logic [XLEN-1:0] acc_addr;

    fetch #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC),
        .NOP      (NOP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .br_true      (br_true),
        .br_decode    (br_decode),
        .jal_take     (jal_take),
        .jal_decode   (jal_decode),
        .jalr_take    (jalr_take),
        .jalr_decode  (jalr_decode),
        .stall_if     (stall_if),
        .pc_decode    (pc_decode),
        .instr_decode (instr_decode),
        .valid_decode (valid_decode)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Instruction memory contents as a pure function of address
    function automatic logic [XLEN-1:0] memf(input logic [XLEN-1:0] a);
        if (a == 32'h0000_0008) return 32'h0000_DEAD;
        if (a == 32'h0000_0020) return 32'h00A0_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    // Close the current cycle: model bookkeeping before the edge, memory drive after it
    task automatic tick();
        #1;
        acc_now = 1'b0;
        if (rst) begin
            exp_pc = RESET_PC;
            pend   = 1'b0;
        end else begin
            if (chk_en) begin
                if (pend) begin
                    total++;
                    if (imem_req !== 1'b0) begin
                        bad++;
                        $display("FAIL req_while_outstanding: req=%b want 0", imem_req);
                    end
                end
                if (imem_req === 1'b1) begin
                    total++;
                    if (imem_addr[1:0] !== 2'b00) begin
                        bad++;
                        $display("FAIL addr_align: addr=%h", imem_addr);
                    end
                end
                if (valid_decode === 1'b0) begin
                    total++;
                    if (pc_decode !== '0 || instr_decode !== NOP) begin
                        bad++;
                        $display("FAIL bubble_content: pc=%h instr=%h want 0/%h", pc_decode, instr_decode, NOP);
                    end
                end
                if (valid_decode === 1'b1 && !stall_if) begin
                    total++;
                    if (pc_decode !== exp_pc || instr_decode !== memf(exp_pc)) begin
                        bad++;
                        $display("FAIL stream: pc=%h instr=%h want pc=%h instr=%h",
                                 pc_decode, instr_decode, exp_pc, memf(exp_pc));
                    end
                    exp_pc = exp_pc + 32'd4;
                    n_cons++;
                end
            end
            if (jalr_take)      exp_pc = jalr_decode;
            else if (jal_take)  exp_pc = jal_decode;
            else if (br_true)   exp_pc = br_decode;
            if (imem_rvalid) pend = 1'b0;
            if (imem_req === 1'b1 && imem_gnt) begin
                acc_now   = 1'b1;
                acc_addr  = imem_addr;
                pend      = 1'b1;
                pend_addr = imem_addr;
                pend_cnt  = lat_rand ? int'($urandom_range(1, 3)) : lat;
            end
        end
        @(posedge clk);
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memf(pend_addr);
            end
        end
        imem_gnt = ($urandom_range(0, 99) < gnt_pct);
    endtask

    task automatic wait_acc(input int budget, output bit got, output logic [XLEN-1:0] a);
        got = 1'b0;
        a   = '0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            if (acc_now) begin
                got = 1'b1;
                a   = acc_addr;
            end
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        chk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (imem_req !== 1'b0 || valid_decode !== 1'b0 || pc_decode !== '0 || instr_decode !== NOP) begin
                bad++;
                $display("FAIL reset_state cyc%0d: req=%b valid=%b pc=%h instr=%h want 0/0/0/%h",
                         i, imem_req, valid_decode, pc_decode, instr_decode, NOP);
            end
        end
        rst    = 1'b0;
        chk_en = 1'b1;
        #1;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            bad++;
            $display("FAIL first_req: req=%b addr=%h want 1/%h", imem_req, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_sequential();
        logic [5:0]      v;
        logic [XLEN-1:0] addrs[$];
        bit              ok;
        v = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (acc_now) addrs.push_back(acc_addr);
            v = {v[4:0], valid_decode};
        end
        ok = (addrs.size() == 3);
        if (ok) ok = (addrs[0] === 32'h0) && (addrs[1] === 32'h4) && (addrs[2] === 32'h8);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL seq_addrs: got %0d accepts (first %h) want 0,4,8", addrs.size(),
                     (addrs.size() > 0) ? addrs[0] : 32'hFFFF_FFFF);
        end
        total++;
        if (v !== 6'b010101) begin
            bad++;
            $display("FAIL seq_valid_pattern: got %b want 010101", v);
        end
        total++;
        if (pc_decode !== 32'h8 || instr_decode !== memf(32'h8)) begin
            bad++;
            $display("FAIL seq_third: pc=%h instr=%h want 8/%h", pc_decode, instr_decode, memf(32'h8));
        end
    endtask

    task automatic test_branch();
        bit              found;
        bit              got;
        logic [XLEN-1:0] a;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            #1;
            if (imem_req === 1'b1) found = 1'b1;
            else tick();
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL branch_setup: req never rose, got 0 want 1");
        end
        br_true   = 1'b1;
        br_decode = 32'h100;
        #1;
        total++;
        if (imem_req !== 1'b0) begin
            bad++;
            $display("FAIL branch_req_blocked: req=%b want 0", imem_req);
        end
        tick();
        br_true = 1'b0;
        total++;
        if (valid_decode !== 1'b0 || instr_decode !== NOP || pc_decode !== '0) begin
            bad++;
            $display("FAIL branch_bubble: valid=%b instr=%h pc=%h want 0/%h/0", valid_decode, instr_decode, pc_decode, NOP);
        end
        wait_acc(10, got, a);
        total++;
        if (!got || a !== 32'h100) begin
            bad++;
            $display("FAIL branch_target: got %h (seen=%0d) want 00000100", a, got);
        end
    endtask

    task automatic test_jalr_drop();
        bit              got;
        bit              dead;
        logic [XLEN-1:0] a;
        lat       = 3;
        br_true   = 1'b1;
        br_decode = 32'h8;
        tick();
        br_true = 1'b0;
        wait_acc(20, got, a);
        total++;
        if (!got || a !== 32'h8) begin
            bad++;
            $display("FAIL drop_setup: got %h want 00000008", a);
        end
        jalr_take   = 1'b1;
        jalr_decode = 32'h40;
        tick();
        jalr_take = 1'b0;
        got  = 1'b0;
        dead = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            tick();
            if (valid_decode === 1'b1 && instr_decode === 32'h0000_DEAD) dead = 1'b1;
            if (acc_now) begin
                got = 1'b1;
                a   = acc_addr;
            end
        end
        total++;
        if (dead) begin
            bad++;
            $display("FAIL drop_leak: stale 0000dead reached decode, want discarded");
        end
        total++;
        if (!got || a !== 32'h40) begin
            bad++;
            $display("FAIL drop_target: got %h want 00000040", a);
        end
        // Redirect in the very cycle the response returns
        for (int i = 0; i < 6; i++) begin
            #1;
            if (imem_rvalid) break;
            tick();
        end
        jal_take   = 1'b1;
        jal_decode = 32'h80;
        tick();
        jal_take = 1'b0;
        #1;
        total++;
        if (valid_decode !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h80) begin
            bad++;
            $display("FAIL redirect_with_rvalid: valid=%b req=%b addr=%h want 0/1/00000080", valid_decode, imem_req, imem_addr);
        end
        lat = 1;
    endtask

    task automatic test_stall();
        bit              got;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] s_pc;
        logic [XLEN-1:0] s_instr;
        logic            s_val;
        br_true   = 1'b1;
        br_decode = 32'h20;
        tick();
        br_true = 1'b0;
        wait_acc(10, got, a);
        total++;
        if (!got || a !== 32'h20) begin
            bad++;
            $display("FAIL stall_setup: got %h want 00000020", a);
        end
        stall_if = 1'b1;
        s_pc     = pc_decode;
        s_instr  = instr_decode;
        s_val    = valid_decode;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (pc_decode !== s_pc || instr_decode !== s_instr || valid_decode !== s_val || imem_req !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold cyc%0d: pc=%h instr=%h valid=%b req=%b want %h/%h/%b/0",
                         i, pc_decode, instr_decode, valid_decode, imem_req, s_pc, s_instr, s_val);
            end
        end
        stall_if = 1'b0;
        tick();
        total++;
        if (instr_decode !== 32'h00A0_0093 || pc_decode !== 32'h20 || valid_decode !== 1'b1) begin
            bad++;
            $display("FAIL stall_release: instr=%h pc=%h valid=%b want 00a00093/00000020/1", instr_decode, pc_decode, valid_decode);
        end
        wait_acc(10, got, a);
        total++;
        if (!got || a !== 32'h24) begin
            bad++;
            $display("FAIL stall_resume: got %h want 00000024", a);
        end
    endtask

    task automatic test_prio_wrap();
        bit              got;
        logic [XLEN-1:0] a;
        jal_take   = 1'b1;
        jal_decode = 32'h200;
        br_true    = 1'b1;
        br_decode  = 32'h300;
        tick();
        jal_take = 1'b0;
        br_true  = 1'b0;
        wait_acc(10, got, a);
        total++;
        if (!got || a !== 32'h200) begin
            bad++;
            $display("FAIL priority: got %h want 00000200", a);
        end
        jalr_take   = 1'b1;
        jalr_decode = 32'hFFFF_FFFC;
        tick();
        jalr_take = 1'b0;
        wait_acc(10, got, a);
        total++;
        if (!got || a !== 32'hFFFF_FFFC) begin
            bad++;
            $display("FAIL wrap_setup: got %h want fffffffc", a);
        end
        wait_acc(10, got, a);
        total++;
        if (!got || a !== 32'h0) begin
            bad++;
            $display("FAIL wrap: got %h want 00000000", a);
        end
    endtask

    task automatic test_reset_midflight();
        bit              got;
        logic [XLEN-1:0] a;
        stall_if  = 1'b1;
        br_true   = 1'b1;
        br_decode = 32'h60;
        tick();
        br_true = 1'b0;
        wait_acc(10, got, a);
        total++;
        if (!got || a !== 32'h60) begin
            bad++;
            $display("FAIL rstbuf_setup: got %h want 00000060", a);
        end
        tick();
        rst = 1'b1;
        tick();
        total++;
        if (pc_decode !== '0 || instr_decode !== NOP || valid_decode !== 1'b0 || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL rstbuf_state: pc=%h instr=%h valid=%b req=%b want 0/%h/0/0", pc_decode, instr_decode, valid_decode, imem_req, NOP);
        end
        rst      = 1'b0;
        stall_if = 1'b0;
        lat      = 3;
        #1;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            bad++;
            $display("FAIL rstbuf_req: req=%b addr=%h want 1/%h", imem_req, imem_addr, RESET_PC);
        end
        tick();
        total++;
        if (valid_decode !== 1'b0) begin
            bad++;
            $display("FAIL rstbuf_cleared: valid=%b want 0", valid_decode);
        end
        // Reset while a read is outstanding
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lat = 1;
        #1;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            bad++;
            $display("FAIL rstwait_req: req=%b addr=%h want 1/%h", imem_req, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_random();
        int start;
        start    = n_cons;
        lat_rand = 1'b1;
        gnt_pct  = 70;
        for (int i = 0; i < 3000; i++) begin
            stall_if    = ($urandom_range(0, 99) < 30);
            br_true     = ($urandom_range(0, 39) == 0);
            jal_take    = ($urandom_range(0, 59) == 0);
            jalr_take   = ($urandom_range(0, 79) == 0);
            br_decode   = $urandom & 32'h0000_0FFC;
            jal_decode  = $urandom & 32'h0000_0FFC;
            jalr_decode = $urandom & 32'h0000_0FFC;
            tick();
        end
        stall_if  = 1'b0;
        br_true   = 1'b0;
        jal_take  = 1'b0;
        jalr_take = 1'b0;
        total++;
        if (n_cons - start < 200) begin
            bad++;
            $display("FAIL random_progress: consumed %0d want >= 200", n_cons - start);
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        chk_en      = 1'b0;
        exp_pc      = RESET_PC;
        n_cons      = 0;
        pend        = 1'b0;
        pend_addr   = '0;
        pend_cnt    = 0;
        lat         = 1;
        lat_rand    = 1'b0;
        gnt_pct     = 100;
        acc_now     = 1'b0;
        acc_addr    = '0;
        rst         = 1'b1;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        br_true     = 1'b0;
        br_decode   = '0;
        jal_take    = 1'b0;
        jal_decode  = '0;
        jalr_take   = 1'b0;
        jalr_decode = '0;
        stall_if    = 1'b0;

        test_reset();
        test_sequential();
        test_branch();
        test_jalr_drop();
        test_stall();
        test_prio_wrap();
        test_reset_midflight();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
